// File: rtl/aurora_ll_pkg.sv
// Shared types and constants for the Aurora LocalLink scheduler.
// Holds the controller state encoding, the fixed frame header and length,
// and a helper that builds any word of the 4-word status frame.
package aurora_ll_pkg;

  typedef enum logic [2:0] {
    StGtRst,
    StCoreRst,
    StWaitUp,
    StIdle,
    StSend
  } state_e;

  localparam logic [7:0]  FrameHdr = 8'hA5;
  localparam int unsigned FrameLen = 4;

  typedef logic [$clog2(FrameLen)-1:0] word_idx_t;

  // W0 = {hdr, seq}, W1 = {0, p}, W2 = {0, ~p}, W3 = 16-bit sum of W0..W2.
  function automatic logic [15:0] frame_word(input word_idx_t  idx,
                                             input logic [7:0] seq,
                                             input logic [7:0] p);
    logic [15:0] w0, w1, w2;
    w0 = {FrameHdr, seq};
    w1 = {8'h00, p};
    w2 = {8'h00, ~p};
    case (idx)
      2'd0:    frame_word = w0;
      2'd1:    frame_word = w1;
      2'd2:    frame_word = w2;
      default: frame_word = w0 + w1 + w2;
    endcase
  endfunction

endpackage

// File: rtl/aurora_cc_gen.sv
// Clock-compensation request generator.
// A free-running counter cycles 0..CC_PERIOD-1; WARN_CC covers the WARN_LEAD
// counts just before the DO_CC window, DO_CC covers the last CC_LEN counts.
// Both flags are registered and track the counter value of the same cycle.
// Ports:
//   clk_i      - transceiver user clock
//   reset_i    - synchronous, active-high
//   warn_cc_o  - registered warning flag
//   do_cc_o    - registered compensation request
// Requires CC_PERIOD > CC_LEN + WARN_LEAD.
module aurora_cc_gen #(
  parameter int unsigned CC_PERIOD = 5000,
  parameter int unsigned CC_LEN    = 6,
  parameter int unsigned WARN_LEAD = 5
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic warn_cc_o,
  output logic do_cc_o
);

  localparam int unsigned CntW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CC_PERIOD - 1);
  localparam logic [CntW-1:0] WarnLo  = CntW'(CC_PERIOD - CC_LEN - WARN_LEAD);
  localparam logic [CntW-1:0] DoLo    = CntW'(CC_PERIOD - CC_LEN);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            warn_q, warn_d;
  logic            do_q, do_d;

  // Flags are decoded from the next count so the registered outputs line up
  // with the counter value they describe.
  always_comb begin
    cnt_d  = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
    warn_d = (cnt_d >= WarnLo) && (cnt_d < DoLo);
    do_d   = (cnt_d >= DoLo);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      warn_q <= 1'b0;
      do_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      warn_q <= warn_d;
      do_q   <= do_d;
    end
  end

  assign warn_cc_o = warn_q;
  assign do_cc_o   = do_q;

endmodule

// File: rtl/aurora_ll_sched.sv
// Aurora 16-bit LocalLink controller.
// Sequences GT and core reset, waits for CHANNEL_UP (retrying on timeout),
// drives periodic clock compensation and frames a latched status byte into
// fixed 4-word LocalLink frames with SRC/DST ready handshaking.
// Ports:
//   clk, reset            - user clock, synchronous active-high reset
//   tx_req, payload       - level request and status byte; tx_ack pulses on accept
//   GT_RESET, RESET_CORE  - core reset controls; CHANNEL_UP from core
//   WARN_CC, DO_CC        - clock-compensation controls
//   TX_*                  - LocalLink source interface; TX_DST_RDY_N from core
//   busy                  - high outside IDLE
//   frames_sent           - completed frames, wraps
//   link_drops            - link losses and bring-up timeouts, saturates at 255
module aurora_ll_sched
  import aurora_ll_pkg::*;
#(
  parameter int unsigned GT_RST_CYC   = 16,
  parameter int unsigned CORE_RST_CYC = 16,
  parameter int unsigned UP_TIMEOUT   = 65535,
  parameter int unsigned CC_PERIOD    = 5000,
  parameter int unsigned CC_LEN       = 6,
  parameter int unsigned WARN_LEAD    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_req,
  input  logic [7:0]  payload,
  output logic        tx_ack,
  output logic        GT_RESET,
  output logic        RESET_CORE,
  input  logic        CHANNEL_UP,
  output logic        WARN_CC,
  output logic        DO_CC,
  output logic [15:0] TX_D,
  output logic        TX_REM,
  output logic        TX_SRC_RDY_N,
  output logic        TX_SOF_N,
  output logic        TX_EOF_N,
  input  logic        TX_DST_RDY_N,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic [7:0]  link_drops
);

  localparam word_idx_t LastWord = word_idx_t'(FrameLen - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  word_idx_t   idx_q, idx_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  pay_q, pay_d;
  logic [15:0] frames_q, frames_d;
  logic [7:0]  drops_q, drops_d;
  logic        drop_evt;
  logic        in_send;

  aurora_cc_gen #(
    .CC_PERIOD (CC_PERIOD),
    .CC_LEN    (CC_LEN),
    .WARN_LEAD (WARN_LEAD)
  ) u_cc_gen (
    .clk_i     (clk),
    .reset_i   (reset),
    .warn_cc_o (WARN_CC),
    .do_cc_o   (DO_CC)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = 16'd0;
    idx_d    = idx_q;
    seq_d    = seq_q;
    pay_d    = pay_q;
    frames_d = frames_q;
    drop_evt = 1'b0;
    tx_ack   = 1'b0;
    unique case (state_q)
      StGtRst: begin
        if (cnt_q == 16'(GT_RST_CYC - 1)) state_d = StCoreRst;
        else                              cnt_d   = cnt_q + 16'd1;
      end
      StCoreRst: begin
        if (cnt_q == 16'(CORE_RST_CYC - 1)) state_d = StWaitUp;
        else                                cnt_d   = cnt_q + 16'd1;
      end
      StWaitUp: begin
        if (CHANNEL_UP) begin
          state_d = StIdle;
        end else if (cnt_q == 16'(UP_TIMEOUT - 1)) begin
          state_d  = StGtRst;
          drop_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StIdle: begin
        // Link loss takes priority over a pending request.
        if (!CHANNEL_UP) begin
          state_d  = StWaitUp;
          drop_evt = 1'b1;
        end else if (tx_req) begin
          tx_ack  = 1'b1;
          pay_d   = payload;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        // Abort beats a same-cycle transfer: the frame is discarded uncounted.
        if (!CHANNEL_UP) begin
          state_d  = StWaitUp;
          drop_evt = 1'b1;
        end else if (!TX_DST_RDY_N) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LastWord) begin
            frames_d = frames_q + 16'd1;
            seq_d    = seq_q + 8'd1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StGtRst;
    endcase
    drops_d = (drop_evt && drops_q != 8'hFF) ? drops_q + 8'd1 : drops_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StGtRst;
      cnt_q    <= 16'd0;
      idx_q    <= '0;
      seq_q    <= 8'd0;
      pay_q    <= 8'd0;
      frames_q <= 16'd0;
      drops_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      pay_q    <= pay_d;
      frames_q <= frames_d;
      drops_q  <= drops_d;
    end
  end

  // LocalLink outputs decode from registered state, so they stay stable while
  // the core withholds TX_DST_RDY_N.
  assign in_send      = (state_q == StSend);
  assign GT_RESET     = (state_q == StGtRst);
  assign RESET_CORE   = (state_q == StGtRst) || (state_q == StCoreRst);
  assign busy         = (state_q != StIdle);
  assign TX_SRC_RDY_N = !in_send;
  assign TX_SOF_N     = !(in_send && idx_q == '0);
  assign TX_EOF_N     = !(in_send && idx_q == LastWord);
  assign TX_D         = in_send ? frame_word(idx_q, seq_q, pay_q) : 16'h0000;
  assign TX_REM       = 1'b1;
  assign frames_sent  = frames_q;
  assign link_drops   = drops_q;

endmodule

// File: tb/tb_aurora_ll_sched.sv
module tb_aurora_ll_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_req;
  logic [7:0]  payload;
  logic        tx_ack;
  logic        GT_RESET, RESET_CORE, CHANNEL_UP, WARN_CC, DO_CC;
  logic [15:0] TX_D;
  logic        TX_REM, TX_SRC_RDY_N, TX_SOF_N, TX_EOF_N, TX_DST_RDY_N;
  logic        busy;
  logic [15:0] frames_sent;
  logic [7:0]  link_drops;

  int checks = 0;
  int errors = 0;
  int word_cyc = 0;

  always #5 clk = ~clk;

  aurora_ll_sched #(
    .GT_RST_CYC   (16),
    .CORE_RST_CYC (16),
    .UP_TIMEOUT   (100),
    .CC_PERIOD    (20),
    .CC_LEN       (6),
    .WARN_LEAD    (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_req       (tx_req),
    .payload      (payload),
    .tx_ack       (tx_ack),
    .GT_RESET     (GT_RESET),
    .RESET_CORE   (RESET_CORE),
    .CHANNEL_UP   (CHANNEL_UP),
    .WARN_CC      (WARN_CC),
    .DO_CC        (DO_CC),
    .TX_D         (TX_D),
    .TX_REM       (TX_REM),
    .TX_SRC_RDY_N (TX_SRC_RDY_N),
    .TX_SOF_N     (TX_SOF_N),
    .TX_EOF_N     (TX_EOF_N),
    .TX_DST_RDY_N (TX_DST_RDY_N),
    .busy         (busy),
    .frames_sent  (frames_sent),
    .link_drops   (link_drops)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [15:0] d, input logic sof,
                          input logic eof);
    word_cyc++;
    check({tag, "_d"}, TX_D, d);
    check({tag, "_sof"}, TX_SOF_N, sof);
    check({tag, "_eof"}, TX_EOF_N, eof);
    check({tag, "_src"}, TX_SRC_RDY_N, 1'b0);
    check({tag, "_rem"}, TX_REM, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_gt"}, GT_RESET, 1'b1);
    check({tag, "_rc"}, RESET_CORE, 1'b1);
    check({tag, "_src"}, TX_SRC_RDY_N, 1'b1);
    check({tag, "_sof"}, TX_SOF_N, 1'b1);
    check({tag, "_eof"}, TX_EOF_N, 1'b1);
    check({tag, "_d"}, TX_D, 16'h0000);
    check({tag, "_rem"}, TX_REM, 1'b1);
    check({tag, "_warn"}, WARN_CC, 1'b0);
    check({tag, "_do"}, DO_CC, 1'b0);
    check({tag, "_ack"}, tx_ack, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_frames"}, frames_sent, 16'd0);
    check({tag, "_drops"}, link_drops, 8'd0);
  endtask

  // Accept a request in IDLE and advance to the first SEND cycle.
  task automatic request(input logic [7:0] p, input logic hold);
    payload = p;
    tx_req  = 1'b1;
    #1;
    check("ack", tx_ack, 1'b1);
    step();
    if (!hold) tx_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m;
    reset        = 1'b1;
    tx_req       = 1'b0;
    payload      = 8'h00;
    CHANNEL_UP   = 1'b0;
    TX_DST_RDY_N = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("in_reset");
    reset = 1'b0;

    // Bring-up: cycle c counts edges since reset release.
    for (int c = 0; c <= 40; c++) begin
      if (c == 40) CHANNEL_UP = 1'b1;
      m = c % 20;
      check($sformatf("bu_gt_%0d", c), GT_RESET, (c < 16));
      check($sformatf("bu_rc_%0d", c), RESET_CORE, (c < 32));
      check($sformatf("bu_busy_%0d", c), busy, 1'b1);
      check($sformatf("cc_warn_%0d", c), WARN_CC, (m >= 9 && m <= 13));
      check($sformatf("cc_do_%0d", c), DO_CC, (m >= 14));
      step();
    end
    check("bu_idle", busy, 1'b0);
    check("bu_gt_low", GT_RESET, 1'b0);
    check("bu_rc_low", RESET_CORE, 1'b0);
    check("bu_drops", link_drops, 8'd0);

    // Single frame, seq 00, payload 3C.
    request(8'h3C, 1'b0);
    chk_word("f1_w0", 16'hA500, 1'b0, 1'b1); step();
    chk_word("f1_w1", 16'h003C, 1'b1, 1'b1); step();
    chk_word("f1_w2", 16'h00C3, 1'b1, 1'b1); step();
    chk_word("f1_w3", 16'hA5FF, 1'b1, 1'b0); step();
    check("f1_src_off", TX_SRC_RDY_N, 1'b1);
    check("f1_frames", frames_sent, 16'd1);
    check("f1_idle", busy, 1'b0);

    // Backpressure on W1 for three cycles, seq 01, payload 5A.
    word_cyc = 0;
    request(8'h5A, 1'b0);
    chk_word("bp_w0", 16'hA501, 1'b0, 1'b1); step();
    TX_DST_RDY_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) TX_DST_RDY_N = 1'b0;
      chk_word($sformatf("bp_w1_%0d", k), 16'h005A, 1'b1, 1'b1);
      step();
    end
    chk_word("bp_w2", 16'h00A5, 1'b1, 1'b1); step();
    chk_word("bp_w3", 16'hA600, 1'b1, 1'b0); step();
    check("bp_src_off", TX_SRC_RDY_N, 1'b1);
    check("bp_send_cycles", word_cyc, 7);
    check("bp_frames", frames_sent, 16'd2);

    // Reset mid-frame drops the frame and restores reset values.
    request(8'hAA, 1'b0);
    step();
    check("mr_w1", TX_D, 16'h00AA);
    reset = 1'b1;
    step();
    chk_reset_vals("mid_reset");
    reset = 1'b0;
    for (int i = 0; i < 60 && busy; i++) step();
    check("mr_rebringup", busy, 1'b0);

    // Back-to-back frames with tx_req held, seq 00 then 01.
    request(8'h01, 1'b1);
    chk_word("bb0_w0", 16'hA500, 1'b0, 1'b1); step();
    chk_word("bb0_w1", 16'h0001, 1'b1, 1'b1); step();
    chk_word("bb0_w2", 16'h00FE, 1'b1, 1'b1); step();
    chk_word("bb0_w3", 16'hA5FF, 1'b1, 1'b0); step();
    check("bb_gap_src", TX_SRC_RDY_N, 1'b1);
    check("bb_gap_sof", TX_SOF_N, 1'b1);
    request(8'h01, 1'b1);
    chk_word("bb1_w0", 16'hA501, 1'b0, 1'b1); step();
    chk_word("bb1_w1", 16'h0001, 1'b1, 1'b1); step();
    chk_word("bb1_w2", 16'h00FE, 1'b1, 1'b1); step();
    chk_word("bb1_w3", 16'hA600, 1'b1, 1'b0);
    tx_req = 1'b0;
    step();
    #1;
    check("bb_no_ack", tx_ack, 1'b0);
    check("bb_frames", frames_sent, 16'd2);

    // Link loss while W2 is presented, seq 02.
    request(8'h77, 1'b0);
    chk_word("ll_w0", 16'hA502, 1'b0, 1'b1); step();
    chk_word("ll_w1", 16'h0077, 1'b1, 1'b1); step();
    chk_word("ll_w2", 16'h0088, 1'b1, 1'b1);
    CHANNEL_UP = 1'b0;
    step();
    check("ll_src_off", TX_SRC_RDY_N, 1'b1);
    check("ll_no_eof", TX_EOF_N, 1'b1);
    check("ll_drops", link_drops, 8'd1);
    check("ll_frames", frames_sent, 16'd2);
    check("ll_busy", busy, 1'b1);
    CHANNEL_UP = 1'b1;
    step();
    check("ll_recover", busy, 1'b0);
    request(8'h77, 1'b0);
    chk_word("lr_w0", 16'hA502, 1'b0, 1'b1); step();
    chk_word("lr_w1", 16'h0077, 1'b1, 1'b1); step();
    chk_word("lr_w2", 16'h0088, 1'b1, 1'b1); step();
    chk_word("lr_w3", 16'hA601, 1'b1, 1'b0); step();
    check("lr_frames", frames_sent, 16'd3);

    // Link loss in IDLE, then bring-up timeout after 100 cycles.
    CHANNEL_UP = 1'b0;
    step();
    check("to_drops_idle", link_drops, 8'd2);
    tx_req = 1'b1;
    #1;
    check("to_req_ignored", tx_ack, 1'b0);
    tx_req = 1'b0;
    repeat (99) step();
    check("to_gt_before", GT_RESET, 1'b0);
    check("to_drops_before", link_drops, 8'd2);
    step();
    check("to_gt_after", GT_RESET, 1'b1);
    check("to_rc_after", RESET_CORE, 1'b1);
    check("to_drops_after", link_drops, 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
